// File: rtl/cdb_arbiter.sv
// cdb_arbiter: parks each FU completion in a one-entry buffer and broadcasts one result per cycle on a registered CDB.
// Latency: 2 cycles best case from FU handshake to CDB_valid. A buffer that is granted can be refilled in the same cycle.
// Backpressure: fu_ready[i] drops while buffer i is full and not granted, and drops for every FU while branch_not_taken is high.
// Build option: define CDB_RR_EN for round-robin arbitration. Otherwise fixed priority applies and the highest index wins.
module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0] fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic                          branch_not_taken,
  output logic                          CDB_valid,
  output logic [TAG_W-1:0]              CDB_tag,
  output logic [DATA_W-1:0]             CDB_value,
  output logic                          CAM_en,
  output logic [$clog2(NUM_FU+1)-1:0]   buf_cnt
);
  localparam int CNT_W = $clog2(NUM_FU + 1);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] buf_valid;
  logic [TAG_W-2:0]  buf_tag   [NUM_FU];
  logic [DATA_W-1:0] buf_value [NUM_FU];
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] load;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  scan_idx;
  // The incoming ready bit is not stored. The CDB always forces it to 1.
  logic [NUM_FU-1:0] unused_fu_tag_rdy;

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   scan_sum;

  // Round-robin search. The first valid buffer at or above rr_ptr wins, and the search wraps modulo NUM_FU.
  // The scan runs from the largest offset down, so the smallest offset is written last and takes precedence.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    scan_sum = '0;
    for (int off = NUM_FU - 1; off >= 0; off--) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (scan_sum >= (IDX_W+1)'(NUM_FU))
        scan_sum = scan_sum - (IDX_W+1)'(NUM_FU);
      scan_idx = scan_sum[IDX_W-1:0];
      if (buf_valid[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Priority pointer moves past the winner. Idle cycles and squash cycles hold it.
  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (|grant)
      rr_ptr <= (win_idx == IDX_W'(NUM_FU - 1)) ? '0 : win_idx + IDX_W'(1);
  end
`else
  // Fixed priority. The highest valid index wins, which matches the RS selector.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_idx = IDX_W'(i);
      if (buf_valid[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end
`endif

  // One-hot grant. A squash cycle suppresses it, so a doomed result is never broadcast.
  always_comb begin
    grant = '0;
    if (win_vld && !branch_not_taken)
      grant[win_idx] = 1'b1;
  end

  assign fu_ready = {NUM_FU{~branch_not_taken}} & (~buf_valid | grant);
  assign load     = fu_valid & fu_ready;

  // Occupancy. A grant frees the buffer and a load refills it; both can happen in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || branch_not_taken)
      buf_valid <= '0;
    else
      buf_valid <= (buf_valid & ~grant) | load;
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_buf
    assign unused_fu_tag_rdy[g] = fu_tag[g][TAG_W-1];

    // Payload capture on handshake. The valid bit qualifies the payload, so no reset is needed here.
    always_ff @(posedge clock) begin
      if (load[g]) begin
        buf_tag[g]   <= fu_tag[g][TAG_W-2:0];
        buf_value[g] <= fu_value[g];
      end
    end
  end

  // Broadcast register. An idle, squashed or reset cycle parks the bus on an all-ones tag.
  always_ff @(posedge clock) begin
    if (reset || grant == '0) begin
      CDB_valid <= 1'b0;
      CDB_tag   <= '1;
      CDB_value <= '0;
    end else begin
      CDB_valid <= 1'b1;
      CDB_tag   <= {1'b1, buf_tag[win_idx]};
      CDB_value <= buf_value[win_idx];
    end
  end

  assign CAM_en  = CDB_valid;
  assign buf_cnt = CNT_W'($countones(buf_valid));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed expectations for cdb_arbiter.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at that same point.
// Expected values in the arbitration-order tests follow the CDB_RR_EN build option.
module tb_cdb_arbiter;
  localparam int NUM_FU = 5;
  localparam int TAG_W  = 7;
  localparam int DATA_W = 64;

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic [NUM_FU-1:0]             fu_valid = '0;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag = '0;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_value = '0;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          branch_not_taken = 1'b0;
  logic                          CDB_valid;
  logic [TAG_W-1:0]              CDB_tag;
  logic [DATA_W-1:0]             CDB_value;
  logic                          CAM_en;
  logic [2:0]                    buf_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .fu_valid         (fu_valid),
    .fu_tag           (fu_tag),
    .fu_value         (fu_value),
    .fu_ready         (fu_ready),
    .branch_not_taken (branch_not_taken),
    .CDB_valid        (CDB_valid),
    .CDB_tag          (CDB_tag),
    .CDB_value        (CDB_value),
    .CAM_en           (CAM_en),
    .buf_cnt          (buf_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    fu_valid         = '0;
    branch_not_taken = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_bus_idle(input string name);
    chk({name, "_vld"}, 64'(CDB_valid), 64'd0);
    chk({name, "_cam"}, 64'(CAM_en),    64'd0);
    chk({name, "_tag"}, 64'(CDB_tag),   64'h7F);
    chk({name, "_val"}, CDB_value,      64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [NUM_FU];
    logic [NUM_FU-1:0] full_rdy;
    logic [TAG_W-1:0]  starve_c3, starve_c4, mid_tag;
    logic              starve_r2, starve_r3;
`ifdef CDB_RR_EN
    order     = '{0, 1, 2, 3, 4};
    full_rdy  = 5'b00001;
    starve_c3 = 7'h50; starve_c4 = 7'h73;
    starve_r2 = 1'b1;  starve_r3 = 1'b0;
    mid_tag   = 7'h71;
`else
    order     = '{4, 3, 2, 1, 0};
    full_rdy  = 5'b10000;
    starve_c3 = 7'h73; starve_c4 = 7'h50;
    starve_r2 = 1'b0;  starve_r3 = 1'b1;
    mid_tag   = 7'h73;
`endif

    // Reset state held across 3 idle cycles
    do_reset();
    for (int c = 0; c < 3; c++) begin
      chk_bus_idle("rst");
      chk("rst_rdy", 64'(fu_ready), 64'h1F);
      chk("rst_cnt", 64'(buf_cnt),  64'd0);
      tick();
    end

    // Single ALU result, which appears on the bus 2 edges later with the ready bit forced
    fu_valid    = 5'b00001;
    fu_tag[0]   = 7'h05;
    fu_value[0] = 64'h1234;
    tick();
    fu_valid = '0;
    chk("alu_cnt1", 64'(buf_cnt),   64'd1);
    chk("alu_vld1", 64'(CDB_valid), 64'd0);
    tick();
    chk("alu_vld", 64'(CDB_valid), 64'd1);
    chk("alu_cam", 64'(CAM_en),    64'd1);
    chk("alu_tag", 64'(CDB_tag),   64'h45);
    chk("alu_val", CDB_value,      64'h1234);
    chk("alu_cnt", 64'(buf_cnt),   64'd0);
    tick();
    chk_bus_idle("alu_after");

    // All 5 FUs complete together, then drain in arbitration order
    do_reset();
    fu_valid = 5'b11111;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_tag[i]   = 7'(i + 1);
      fu_value[i] = 64'(100 + i);
    end
    #1;
    chk("all_rdy_in", 64'(fu_ready), 64'h1F);
    tick();
    fu_valid = '0;
    #1;
    chk("all_cnt5",   64'(buf_cnt),   64'd5);
    chk("all_vld0",   64'(CDB_valid), 64'd0);
    chk("all_rdy_full", 64'(fu_ready), 64'(full_rdy));
    for (int k = 0; k < NUM_FU; k++) begin
      tick();
      chk("all_vld", 64'(CDB_valid), 64'd1);
      chk("all_tag", 64'(CDB_tag),   64'(7'h40 | 7'(order[k] + 1)));
      chk("all_val", CDB_value,      64'(100 + order[k]));
      chk("all_cnt", 64'(buf_cnt),   64'(NUM_FU - 1 - k));
    end
    tick();
    chk_bus_idle("all_after");

    // FU 0 streams results while FU 3 holds a single result. FU 3 must still be broadcast.
    do_reset();
    fu_valid    = 5'b01001;
    fu_tag[0]   = 7'h10; fu_value[0] = 64'h10;
    fu_tag[3]   = 7'h33; fu_value[3] = 64'h33;
    tick();
    fu_valid    = 5'b00001;
    fu_tag[0]   = 7'h11; fu_value[0] = 64'h11;
    #1;
    chk("stv_rdy_c2", 64'(fu_ready[0]), 64'(starve_r2));
    tick();
    chk("stv_tag_c3", 64'(CDB_tag), 64'(starve_c3));
    if (starve_r2) begin
      fu_tag[0] = 7'h12; fu_value[0] = 64'h12;
    end
    #1;
    chk("stv_rdy_c3", 64'(fu_ready[0]), 64'(starve_r3));
    tick();
    chk("stv_tag_c4", 64'(CDB_tag), 64'(starve_c4));
    fu_tag[0] = 7'h12; fu_value[0] = 64'h12;
    #1;
    chk("stv_rdy_c4", 64'(fu_ready[0]), 64'd1);
    tick();
    fu_valid = '0;
    chk("stv_tag_c5", 64'(CDB_tag), 64'h51);
    tick();
    chk("stv_tag_c6", 64'(CDB_tag),   64'h52);
    chk("stv_val_c6", CDB_value,      64'h12);
    chk("stv_cnt_c6", 64'(buf_cnt),   64'd0);
    tick();
    chk("stv_vld_c7", 64'(CDB_valid), 64'd0);

    // Squash with 3 buffers occupied and a BR result offered in the same cycle
    do_reset();
    fu_valid = 5'b00111;
    for (int i = 0; i < 3; i++) begin
      fu_tag[i]   = 7'(8'h21 + i);
      fu_value[i] = 64'(32'hA0 + i);
    end
    tick();
    chk("sq_cnt3", 64'(buf_cnt), 64'd3);
    fu_valid         = 5'b10000;
    fu_tag[4]        = 7'h24;
    fu_value[4]      = 64'hBB;
    branch_not_taken = 1'b1;
    #1;
    chk("sq_rdy", 64'(fu_ready), 64'd0);
    tick();
    branch_not_taken = 1'b0;
    fu_valid         = '0;
    chk("sq_cnt0", 64'(buf_cnt), 64'd0);
    chk_bus_idle("sq_bus");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sq_nostale", 64'(CDB_valid), 64'd0);
    end

    // Reset taken mid-operation while 2 buffers are full and the bus is busy
    do_reset();
    fu_valid = 5'b00111;
    for (int i = 0; i < 3; i++) begin
      fu_tag[i]   = 7'(8'h31 + i);
      fu_value[i] = 64'(32'hC0 + i);
    end
    tick();
    fu_valid = '0;
    tick();
    chk("mid_vld", 64'(CDB_valid), 64'd1);
    chk("mid_tag", 64'(CDB_tag),   64'(mid_tag));
    chk("mid_cnt", 64'(buf_cnt),   64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bus_idle("mid_rst");
    chk("mid_rst_cnt", 64'(buf_cnt), 64'd0);
    #1;
    chk("mid_rst_rdy", 64'(fu_ready), 64'h1F);
    tick();
    chk("mid_post_vld1", 64'(CDB_valid), 64'd0);
    tick();
    chk("mid_post_vld2", 64'(CDB_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
